// File: rtl/sc_et_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sc_et_decoder
// Brief    : Early-terminated stochastic bitstream decoder (ones count scaled
//            by floor(log2 L)). Optional macro: SC_DEC_LEN_CHECK_EN.
// Revision : 1.0
// ============================================================================
module sc_et_decoder #(
    parameter int WIDTH      = 4,
    parameter int NUM_INPUTS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [NUM_INPUTS-1:0]         Xs,
    input  logic                          in_last,
    output logic [NUM_INPUTS*WIDTH-1:0]   Zs,
    output logic                          out_valid,
    output logic [WIDTH*NUM_INPUTS:0]     len,
    output logic                          busy,
    output logic                          ovf,
    output logic                          len_err
);
    localparam int c_LEN_W = WIDTH*NUM_INPUTS + 1;
    localparam int c_K_W   = $clog2(c_LEN_W);
    localparam int c_SH_W  = c_LEN_W + WIDTH;
    localparam logic [c_LEN_W-1:0] c_ONE  = {{(c_LEN_W-1){1'b0}}, 1'b1};
    localparam logic [c_LEN_W-1:0] c_LMAX = {1'b1, {(c_LEN_W-1){1'b0}}};
    localparam logic [c_SH_W-1:0]  c_ZMAX = {{c_LEN_W{1'b0}}, {WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [c_LEN_W-1:0]          r_len_cnt;
    logic [c_LEN_W-1:0]          w_len_next;
    logic [c_LEN_W-1:0]          r_ones      [NUM_INPUTS];
    logic [c_LEN_W-1:0]          w_ones_next [NUM_INPUTS];
    logic [NUM_INPUTS*WIDTH-1:0] w_zs_next;
    logic [NUM_INPUTS*WIDTH-1:0] r_zs;
    logic [c_LEN_W-1:0]          r_len;
    logic [c_K_W-1:0]            w_k;
    logic                        w_accum;
    logic                        w_term;
    logic                        w_ovf_next;
    logic                        w_len_err_next;
    logic                        r_out_valid;
    logic                        r_ovf;
    logic                        r_len_err;

    // Outside ACCUM every valid bit opens a fresh stream, so counters start from zero.
    assign w_accum    = (r_state == S_ACCUM);
    assign w_len_next = (w_accum ? r_len_cnt : '0) + c_ONE;
    assign w_term     = in_valid && (in_last || (w_len_next == c_LMAX));
    assign w_ovf_next = (w_len_next == c_LMAX) && !in_last;

`ifdef SC_DEC_LEN_CHECK_EN
    assign w_len_err_next = |(w_len_next & (w_len_next - c_ONE));
`else
    assign w_len_err_next = 1'b0;
`endif

    always_comb begin
        w_k = '0;
        for (int i = 0; i < c_LEN_W; i++) begin
            if (w_len_next[i]) w_k = c_K_W'(i);
        end
    end

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_stream
        logic [c_SH_W-1:0] w_scaled;
        assign w_ones_next[g] = (w_accum ? r_ones[g] : '0) + {{(c_LEN_W-1){1'b0}}, Xs[g]};
        // Full-width shift so a count equal to L saturates instead of wrapping.
        assign w_scaled = {w_ones_next[g], {WIDTH{1'b0}}} >> w_k;
        assign w_zs_next[g*WIDTH +: WIDTH] =
            (w_scaled > c_ZMAX) ? {WIDTH{1'b1}} : w_scaled[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (in_valid) w_state_next = w_term ? S_DONE : S_ACCUM;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len_cnt   <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) r_ones[i] <= '0;
            r_zs        <= '0;
            r_len       <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_out_valid <= w_term;
            if (in_valid) begin
                r_len_cnt <= w_len_next;
                for (int i = 0; i < NUM_INPUTS; i++) r_ones[i] <= w_ones_next[i];
            end
            if (w_term) begin
                r_zs      <= w_zs_next;
                r_len     <= w_len_next;
                r_ovf     <= w_ovf_next;
                r_len_err <= w_len_err_next;
            end
        end
    end

    assign Zs        = r_zs;
    assign len       = r_len;
    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;
    assign len_err   = r_len_err;
    assign busy      = w_accum;

endmodule
`default_nettype wire
